// File: rtl/logic_unit_sweep_if.sv
`default_nettype none
// ============================================================================
// Module      : logic_unit_sweep_if
// Description : Stimulus/result bus for logic_unit_sweep. The slave side is the
//               logic unit; the master side is the stimulus source/consumer.
// Revision    : 1.0 - initial release
// ============================================================================
interface logic_unit_sweep_if #(
  parameter int WIDTH = 4
);
  logic [2:0]       i_op;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_in_valid;
  logic             o_in_ready;
  logic [WIDTH-1:0] o_y;
  logic             o_out_valid;
  logic             i_out_ready;
  logic             i_sweep_start;
  logic             o_sweep_busy;
  logic             o_sweep_done;

  modport slave (
    input  i_op,
    input  i_a,
    input  i_b,
    input  i_in_valid,
    output o_in_ready,
    output o_y,
    output o_out_valid,
    input  i_out_ready,
    input  i_sweep_start,
    output o_sweep_busy,
    output o_sweep_done
  );

  modport master (
    output i_op,
    output i_a,
    output i_b,
    output i_in_valid,
    input  o_in_ready,
    input  o_y,
    input  o_out_valid,
    output i_out_ready,
    output i_sweep_start,
    input  o_sweep_busy,
    input  o_sweep_done
  );
endinterface
`default_nettype wire

// File: rtl/logic_unit_sweep.sv
`default_nettype none
// ============================================================================
// Module      : logic_unit_sweep
// Description : WIDTH-bit registered bitwise logic unit (8 gate functions) with
//               a one-deep valid/ready output stage and a hardware sweeper that
//               walks every (a,b) pair. Define LOGIC_SIG_EN for the o_sig port.
// Revision    : 1.0 - initial release
// ============================================================================
module logic_unit_sweep #(
  parameter int WIDTH = 4
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  logic_unit_sweep_if.slave bus
`ifdef LOGIC_SIG_EN
  ,
  output logic [WIDTH-1:0]  o_sig
`endif
);

  localparam int             CW         = 2 * WIDTH;
  localparam logic [CW-1:0]  C_CNT_LAST = '1;
  localparam logic [CW-1:0]  C_CNT_ONE  = 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [2:0]       r_sweep_op;
  logic [WIDTH-1:0] r_y;
  logic             r_out_valid;

  logic             w_idle;
  logic             w_sweeping;
  logic             w_draining;
  logic             w_can_load;
  logic             w_take;
  logic             w_src_valid;
  logic             w_accept;
  logic             w_start;
  logic             w_last;
  logic [2:0]       w_src_op;
  logic [WIDTH-1:0] w_src_a;
  logic [WIDTH-1:0] w_src_b;
  logic [WIDTH-1:0] w_result;

  function automatic logic [WIDTH-1:0] f_gate(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [WIDTH-1:0] r;
    case (op)
      3'b000:  r = a & b;
      3'b001:  r = a | b;
      3'b010:  r = ~(a & b);
      3'b011:  r = ~(a | b);
      3'b100:  r = a ^ b;
      3'b101:  r = ~(a ^ b);
      3'b110:  r = ~a;
      default: r = a;
    endcase
    return r;
  endfunction

  assign w_idle     = (r_state == S_IDLE);
  assign w_sweeping = (r_state == S_SWEEP);
  assign w_draining = (r_state == S_DRAIN);

  // The output stage can load whenever it is empty or being emptied this cycle.
  assign w_can_load  = !r_out_valid || bus.i_out_ready;
  assign w_take      = r_out_valid && bus.i_out_ready;
  assign w_src_valid = w_idle ? bus.i_in_valid : w_sweeping;
  assign w_accept    = w_can_load && w_src_valid;
  assign w_start     = w_idle && bus.i_sweep_start;
  assign w_last      = w_sweeping && w_accept && (r_cnt == C_CNT_LAST);

  // The sweeper replaces the external source; a takes the counter's upper half.
  assign w_src_op = w_sweeping ? r_sweep_op          : bus.i_op;
  assign w_src_a  = w_sweeping ? r_cnt[CW-1:WIDTH]   : bus.i_a;
  assign w_src_b  = w_sweeping ? r_cnt[WIDTH-1:0]    : bus.i_b;
  assign w_result = f_gate(w_src_op, w_src_a, w_src_b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.i_sweep_start) w_state_nxt = S_SWEEP;
      S_SWEEP: if (w_last)            w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_take)            w_state_nxt = S_DONE;
      S_DONE:                         w_state_nxt = S_IDLE;
      default:                        w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y         <= '0;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_y         <= w_result;
      r_out_valid <= 1'b1;
    end else if (w_take) begin
      r_out_valid <= 1'b0;
    end
  end

  // The counter parks on all-ones after the final accept instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_sweep_op <= 3'b000;
    end else if (w_start) begin
      r_cnt      <= '0;
      r_sweep_op <= bus.i_op;
    end else if (w_sweeping && w_accept && !w_last) begin
      r_cnt      <= r_cnt + C_CNT_ONE;
    end
  end

  assign bus.o_in_ready   = w_can_load && w_idle;
  assign bus.o_y          = r_y;
  assign bus.o_out_valid  = r_out_valid;
  assign bus.o_sweep_busy = !w_idle;
  assign bus.o_sweep_done = (r_state == S_DONE);

`ifdef LOGIC_SIG_EN
  logic [WIDTH-1:0] r_sig;
  logic [WIDTH-1:0] w_sig_rot;

  generate
    if (WIDTH == 1) begin : g_rot_w1
      assign w_sig_rot = r_sig;
    end else begin : g_rot_wn
      assign w_sig_rot = {r_sig[WIDTH-2:0], r_sig[WIDTH-1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig <= '0;
    end else if (w_start) begin
      r_sig <= '0;
    end else if (w_take && (w_sweeping || w_draining)) begin
      r_sig <= w_sig_rot ^ r_y;
    end
  end

  assign o_sig = r_sig;
`endif

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_sweep.sv
`default_nettype none
// ============================================================================
// Module      : tb_logic_unit_sweep
// Description : Self-checking bench: WIDTH=4 unit against a cycle model plus a
//               beat-order scoreboard, and a WIDTH=1 NAND sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_logic_unit_sweep;
  localparam int W    = 4;
  localparam int N    = 1 << (2 * W);
  localparam int MASK = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst1_n = 1'b0;
  always #5 clk = ~clk;

  logic_unit_sweep_if #(.WIDTH(W)) bus ();
  logic_unit_sweep_if #(.WIDTH(1)) bus1 ();
`ifdef LOGIC_SIG_EN
  logic [W-1:0] sig;
  logic [0:0]   sig1;
`endif

  logic_unit_sweep #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef LOGIC_SIG_EN
    ,
    .o_sig (sig)
`endif
  );

  logic_unit_sweep #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst_n (rst1_n),
    .bus   (bus1)
`ifdef LOGIC_SIG_EN
    ,
    .o_sig (sig1)
`endif
  );

  int errors = 0;
  int checks = 0;
  int beat = 0;
  int done_cnt = 0;
  int exp_sop = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-bit truth table of each gate, built up bit by bit.
  function automatic int gate(input int op, input int a, input int b, input int w);
    int r;
    r = 0;
    for (int i = 0; i < w; i++) begin
      int x;
      int z;
      int o;
      x = (a >> i) & 1;
      z = (b >> i) & 1;
      case (op)
        0:       o = x & z;
        1:       o = x | z;
        2:       o = 1 - (x & z);
        3:       o = 1 - (x | z);
        4:       o = x ^ z;
        5:       o = 1 - (x ^ z);
        6:       o = 1 - x;
        default: o = x;
      endcase
      r = r | (o << i);
    end
    return r;
  endfunction

  // Behavioural model: phase 0 idle, 1 sweeping, 2 draining, 3 done.
  int m_phase = 0;
  int m_idx = 0;
  int m_sop = 0;
  bit m_ov = 1'b0;
  int m_y = 0;
  int m_sig = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_idx = 0; m_sop = 0; m_ov = 1'b0; m_y = 0; m_sig = 0;
    end else begin
      bit can_load;
      bit take;
      bit acc;
      int val;
      can_load = !m_ov || bus.i_out_ready;
      take     = m_ov && bus.i_out_ready;
      acc      = 1'b0;
      val      = 0;
      if (m_phase == 0) begin
        acc = bus.i_in_valid && can_load;
        val = gate(int'(bus.i_op), int'(bus.i_a), int'(bus.i_b), W);
      end else if (m_phase == 1) begin
        acc = can_load;
        val = gate(m_sop, m_idx >> W, m_idx & MASK, W);
      end
      if (take && (m_phase == 1 || m_phase == 2))
        m_sig = (((m_sig << 1) | (m_sig >> (W - 1))) & MASK) ^ m_y;
      if (m_phase == 0 && bus.i_sweep_start) m_sig = 0;
      case (m_phase)
        0: if (bus.i_sweep_start) begin m_phase = 1; m_idx = 0; m_sop = int'(bus.i_op); end
        1: if (acc) begin
             if (m_idx == N - 1) m_phase = 2;
             else m_idx++;
           end
        2: if (take) m_phase = 3;
        default: m_phase = 0;
      endcase
      if (acc) begin
        m_ov = 1'b1;
        m_y  = val;
      end else if (take) begin
        m_ov = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("y", int'(bus.o_y), m_y);
      chk("out_valid", int'(bus.o_out_valid), int'(m_ov));
      chk("in_ready", int'(bus.o_in_ready), int'((!m_ov || bus.i_out_ready) && m_phase == 0));
      chk("sweep_busy", int'(bus.o_sweep_busy), int'(m_phase != 0));
      chk("sweep_done", int'(bus.o_sweep_done), int'(m_phase == 3));
`ifdef LOGIC_SIG_EN
      chk("sig", int'(sig), m_sig);
`endif
      if (bus.o_sweep_busy && bus.o_out_valid && bus.i_out_ready) begin
        chk("beat_order", int'(bus.o_y), gate(exp_sop, beat >> W, beat & MASK, W));
        beat++;
      end
      if (bus.o_sweep_done) done_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_in_valid    = 1'b0;
    bus.i_sweep_start = 1'b0;
    bus.i_out_ready   = 1'b1;
  endtask

  task automatic randomise_ext();
    bus.i_in_valid = 1'($urandom_range(0, 1));
    bus.i_op       = 3'($urandom);
    bus.i_a        = W'($urandom);
    bus.i_b        = W'($urandom);
  endtask

  // Returns at the negedge where sweep_done is seen (or after the bound).
  task automatic wait_done(input int bound, input bit noisy);
    bit got;
    got = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (bus.o_sweep_done) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      if (noisy) begin
        bus.i_out_ready = ~bus.i_out_ready;
        randomise_ext();
      end
    end
    chk("sweep_done_seen", int'(got), 1);
  endtask

  task automatic start_sweep(input int op);
    exp_sop           = op;
    beat              = 0;
    bus.i_op          = 3'(op);
    bus.i_in_valid    = 1'b0;
    bus.i_sweep_start = 1'b1;
    step();
    bus.i_sweep_start = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int q1[$];
    bit got1;
    int d0;

    bus.i_op = 3'd0; bus.i_a = '0; bus.i_b = '0;
    idle_inputs();
    bus1.i_op = 3'b010; bus1.i_a = 1'b0; bus1.i_b = 1'b0;
    bus1.i_in_valid = 1'b0; bus1.i_out_ready = 1'b1; bus1.i_sweep_start = 1'b0;

    // WIDTH=1 NAND sweep: beats 1,1,1,0 then one done pulse.
    repeat (2) step();
    rst1_n = 1'b1;
    step();
    bus1.i_sweep_start = 1'b1;
    step();
    bus1.i_sweep_start = 1'b0;
    got1 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus1.o_sweep_busy && bus1.o_out_valid) q1.push_back(int'(bus1.o_y));
      if (bus1.o_sweep_done) begin
        got1 = 1'b1;
        break;
      end
    end
    chk("w1_done", int'(got1), 1);
    chk("w1_beats", q1.size(), 4);
    if (q1.size() == 4) begin
      chk("w1_beat0", q1[0], 1);
      chk("w1_beat1", q1[1], 1);
      chk("w1_beat2", q1[2], 1);
      chk("w1_beat3", q1[3], 0);
    end
`ifdef LOGIC_SIG_EN
    chk("w1_sig", int'(sig1), 1);
`endif

    // Main unit: reset values.
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_y", int'(bus.o_y), 0);
    chk("rst_out_valid", int'(bus.o_out_valid), 0);
    chk("rst_in_ready", int'(bus.o_in_ready), 1);
    chk("rst_busy", int'(bus.o_sweep_busy), 0);
    chk("rst_done", int'(bus.o_sweep_done), 0);

    // XOR of C and A.
    step();
    bus.i_op = 3'b100; bus.i_a = 4'hC; bus.i_b = 4'hA; bus.i_in_valid = 1'b1;
    step();
    bus.i_in_valid = 1'b0;
    @(negedge clk);
    chk("xor_valid", int'(bus.o_out_valid), 1);
    chk("xor_y", int'(bus.o_y), 6);
    step();
    @(negedge clk);
    chk("xor_valid_clear", int'(bus.o_out_valid), 0);

    // Back-pressure: F&5 held while 3|6 waits, then both move in one cycle.
    step();
    bus.i_out_ready = 1'b0;
    bus.i_op = 3'b000; bus.i_a = 4'hF; bus.i_b = 4'h5; bus.i_in_valid = 1'b1;
    step();
    bus.i_op = 3'b001; bus.i_a = 4'h3; bus.i_b = 4'h6;
    @(negedge clk);
    chk("bp_in_ready", int'(bus.o_in_ready), 0);
    chk("bp_y_first", int'(bus.o_y), 5);
    step();
    @(negedge clk);
    chk("bp_y_held", int'(bus.o_y), 5);
    step();
    bus.i_out_ready = 1'b1;
    @(negedge clk);
    chk("bp_in_ready_release", int'(bus.o_in_ready), 1);
    step();
    bus.i_in_valid = 1'b0;
    @(negedge clk);
    chk("bp_y_second", int'(bus.o_y), 7);
    chk("bp_valid_second", int'(bus.o_out_valid), 1);

    // Random external traffic.
    for (int i = 0; i < 300; i++) begin
      step();
      randomise_ext();
      bus.i_out_ready = ($urandom_range(0, 3) != 0);
    end
    step();
    idle_inputs();
    repeat (3) step();

    // AND sweep, out_ready toggling and external noise.
    start_sweep(0);
    wait_done(4000, 1'b1);
    chk("sweep_and_beats", beat, N);
    step();
    idle_inputs();
    repeat (3) step();

    // Reset mid-sweep at beat 5, then a fresh sweep from zero.
    start_sweep(1);
    for (int i = 0; i < 200 && beat < 5; i++) step();
    chk("abort_reached_beat5", int'(beat >= 5), 1);
    d0 = done_cnt;
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_y", int'(bus.o_y), 0);
    chk("abort_out_valid", int'(bus.o_out_valid), 0);
    chk("abort_busy", int'(bus.o_sweep_busy), 0);
    chk("abort_done", int'(bus.o_sweep_done), 0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (4) step();
    chk("abort_no_done", done_cnt, d0);
    start_sweep(1);
    wait_done(2000, 1'b0);
    chk("restart_beats", beat, N);
    step();

    // sweep_start held high: one sweep, then a second only after IDLE.
    exp_sop = 5;
    beat = 0;
    bus.i_op = 3'b101;
    bus.i_sweep_start = 1'b1;
    step();
    wait_done(2000, 1'b0);
    chk("held_first_beats", beat, N);
    beat = 0;
    step();
    @(negedge clk);
    chk("held_idle_gap", int'(bus.o_sweep_busy), 0);
    step();
    bus.i_sweep_start = 1'b0;
    @(negedge clk);
    chk("held_second_busy", int'(bus.o_sweep_busy), 1);
    wait_done(2000, 1'b0);
    chk("held_second_beats", beat, N);
    step();
    idle_inputs();
    repeat (3) step();
    chk("sweep_count", done_cnt, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
